// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Fetch-side controller for the program counter. Each cycle it decides whether
// the PC advances by one instruction, redirects to a branch target or holds.
// It issues instruction-memory requests, watches for unanswered requests
// (timeout), rejects misaligned branch targets, and counts completed fetches.
//
// Handshake: a fetch completes in a cycle where imem_req and imem_ready are
// both high. In that same cycle pc_load/pc_next advance the PC register, and
// instr_valid pulses for one cycle on the following cycle.
//
// Ports
//   clk            rising-edge clock
//   arst_n         asynchronous active-low reset
//   start          begin fetching (IDLE) or resume (HALTED)
//   halt_req       stop fetching (highest priority in FETCH)
//   stall          hold PC and withdraw the request for this cycle
//   branch_taken   redirect request, with branch_target as the new PC
//   pc_cur         current PC register value
//   pc_next        next value for the PC register
//   pc_load        PC register load enable
//   imem_req       instruction fetch request
//   imem_addr      fetch address (always pc_cur)
//   imem_ready     memory accepts the request / returns the instruction
//   instr_valid    registered pulse: a fetch completed in the previous cycle
//   fetch_count    saturating count of completed fetches
//   busy/halted/fault  state is FETCH / HALTED / FAULT
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR   = '0,
   parameter int unsigned           INSTR_BYTES    = 4,
   parameter int unsigned           TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  start,
   input  logic                  halt_req,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [DATA_WIDTH-1:0] branch_target,
   input  logic [DATA_WIDTH-1:0] pc_cur,
   output logic [DATA_WIDTH-1:0] pc_next,
   output logic                  pc_load,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] fetch_count,
   output logic                  busy,
   output logic                  halted,
   output logic                  fault
);

   localparam int unsigned           TO_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0]       TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0]       TO_ONE     = TO_W'(1);
   localparam logic [DATA_WIDTH-1:0] PC_INC     = DATA_WIDTH'(INSTR_BYTES);
   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'(INSTR_BYTES - 1);
   localparam logic [DATA_WIDTH-1:0] CNT_ONE    = DATA_WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_HALTED = 2'd2,
      S_FAULT  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [TO_W-1:0]       tmo_q, tmo_d;
   logic                  valid_q;
   logic [DATA_WIDTH-1:0] count_q;
   logic                  accept;

   // -------------------------------------------------------------------------
   // Next-state and combinational outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      tmo_d    = tmo_q;
      pc_next  = pc_cur;
      pc_load  = 1'b0;
      imem_req = 1'b0;
      accept   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            pc_next = RESET_VECTOR;
            // Gated by arst_n so pc_load reads 0 while reset is held, even
            // if start is already high.
            pc_load = start & arst_n;
            if (start) begin
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            if (halt_req) begin
               state_d = S_HALTED;
            end else if (branch_taken) begin
               // Redirect cycle: no request, so any concurrent completion is
               // discarded and the fetch restarts at the target next cycle.
               if ((branch_target & ALIGN_MASK) == '0) begin
                  pc_load = 1'b1;
                  pc_next = branch_target;
               end else begin
                  state_d = S_FAULT;
               end
            end else if (stall) begin
               tmo_d = '0;
            end else begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  accept  = 1'b1;
                  pc_load = 1'b1;
                  pc_next = pc_cur + PC_INC;
                  tmo_d   = '0;
               end else if (tmo_q == TO_LAST) begin
                  state_d = S_FAULT;
               end else begin
                  tmo_d = tmo_q + TO_ONE;
               end
            end
         end

         S_HALTED: begin
            // Resume at the current PC; no reload.
            if (start) begin
               state_d = S_FETCH;
            end
         end

         S_FAULT: begin
            // Terminal until reset.
         end

         default: begin
            state_d = S_FAULT;
         end
      endcase

      if (state_d != state_q) begin
         tmo_d = '0;
      end
   end

   // -------------------------------------------------------------------------
   // State and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= S_IDLE;
         tmo_q   <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         valid_q <= accept;
         if (accept && (count_q != '1)) begin
            count_q <= count_q + CNT_ONE;
         end
      end
   end

   assign imem_addr   = pc_cur;
   assign instr_valid = valid_q;
   assign fetch_count = count_q;
   assign busy        = (state_q == S_FETCH);
   assign halted      = (state_q == S_HALTED);
   assign fault       = (state_q == S_FAULT);

endmodule
